axi_mm_ar_arbiter: RTL

- Shares one AXI-MM read-address channel and its read-data return path between NUM_REQ user requesters.
- Sits in front of the AXI-MM master logic-link adapter and drives its user_ar*/user_r* ports.
- Arbitrates AR round-robin behind a one-entry output register.
- Tags each ARID with the requester index, limits outstanding reads per requester, and routes R beats back by ID.

---
 rtl/axi_mm_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/axi_mm_ar_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi_mm_arb_pkg.sv
// Shared types and constants for the AXI-MM read-address arbiter.
//   ar_payload_t : AR fields in logic-link order {id, size, len, burst, addr}, 49 bits
//   r_payload_t  : R beat fields {id, data, resp, last}
package axi_mm_arb_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 128;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [2:0]          size;
        logic [7:0]          len;
        logic [1:0]          burst;
        logic [31:0]         addr;
    } ar_payload_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_payload_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector (one bit per requester)
//   ptr     : index searched first; the search wraps from N-1 to 0
//   gnt     : one-hot grant, all zero when nothing requests
//   gnt_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    logic take;

    // Walk offsets from the pointer; the first requesting slot wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        take    = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                take    = !found && req[j] && (j == ((int'(ptr) + off) % N));
                gnt[j]  = gnt[j] | take;
                gnt_idx = take ? IW'(j) : gnt_idx;
                found   = found | take;
            end
        end
    end

endmodule

// File: rtl/axi_mm_ar_arbiter.sv
// Shares one AXI-MM read-address channel and its R return path between
// NUM_REQ requesters.
//   s_ar*    : per-requester AR inputs (packed, requester i at slice i), s_arready out
//   s_r*     : R beat broadcast to all requesters, s_rvalid/s_rready per requester
//   m_ar*    : registered AR toward the logic-link adapter, ARID = {index, s_arid}
//   m_r*     : R beats from the adapter, routed by ARID index bits
//   outst_cnt: per-requester outstanding bursts (4 bits each)
//   err_sticky: routing or underflow error seen since reset
module axi_mm_ar_arbiter
    import axi_mm_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int REQ_ID_W  = 2,
    parameter int IDX_W     = 2,
    parameter int MAX_OUTST = 8
) (
    input  logic                          clk_wr,
    input  logic                          rst_wr_n,
    input  logic [NUM_REQ*REQ_ID_W-1:0]   s_arid,
    input  logic [NUM_REQ*32-1:0]         s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    input  logic [NUM_REQ*3-1:0]          s_arsize,
    input  logic [NUM_REQ*2-1:0]          s_arburst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [REQ_ID_W-1:0]           s_rid,
    output logic [AXI_DATA_W-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [AXI_ID_W-1:0]           m_arid,
    output logic [31:0]                   m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [AXI_ID_W-1:0]           m_rid,
    input  logic [AXI_DATA_W-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [NUM_REQ*4-1:0]          outst_cnt,
    output logic                          err_sticky
);

    logic [IDX_W-1:0]         ptr_q, ptr_d;
    ar_payload_t              ar_q, ar_d, ar_sel_s, ar_cand_s;
    logic                     arvalid_q, arvalid_d;
    logic [NUM_REQ-1:0][3:0]  outst_q, outst_d;
    logic                     err_q, err_d;

    logic [NUM_REQ-1:0]       eligible_s, req_s, gnt_s;
    logic [IDX_W-1:0]         gnt_idx_s;
    logic                     load_ok_s, accept_s;

    r_payload_t               r_s;
    logic [IDX_W-1:0]         r_idx_s;
    logic                     route_ok_s, rready_sel_s, m_rready_s, retire_s;
    logic [NUM_REQ-1:0]       hit_s;

    // Requesters at their outstanding limit are masked so the others keep flowing.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = s_arvalid[i] && (outst_q[i] < 4'(MAX_OUTST));
        end
        load_ok_s = !arvalid_q || m_arready;
        req_s     = load_ok_s ? eligible_s : '0;
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req     (req_s),
        .ptr     (ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign accept_s  = |gnt_s;
    assign s_arready = gnt_s;

    // One-hot AND-OR mux of the winner's AR payload, index bits prepended to ARID.
    always_comb begin
        ar_sel_s  = '0;
        ar_cand_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ar_cand_s.id    = {IDX_W'(i), s_arid[i*REQ_ID_W +: REQ_ID_W]};
            ar_cand_s.size  = s_arsize[i*3 +: 3];
            ar_cand_s.len   = s_arlen[i*8 +: 8];
            ar_cand_s.burst = s_arburst[i*2 +: 2];
            ar_cand_s.addr  = s_araddr[i*32 +: 32];
            ar_sel_s        = ar_sel_s | (ar_cand_s & {$bits(ar_payload_t){gnt_s[i]}});
        end
    end

    // Output register: load on a grant, drop valid when drained with nothing to load.
    always_comb begin
        ar_d      = ar_q;
        arvalid_d = arvalid_q;
        ptr_d     = ptr_q;
        if (accept_s) begin
            ar_d      = ar_sel_s;
            arvalid_d = 1'b1;
            if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + IDX_W'(1);
            end
        end else if (load_ok_s) begin
            arvalid_d = 1'b0;
        end else begin
            arvalid_d = arvalid_q;
        end
    end

    // R routing by ARID index; beats for a nonexistent requester are swallowed.
    always_comb begin
        r_s          = '{id: m_rid, data: m_rdata, resp: m_rresp, last: m_rlast};
        r_idx_s      = r_s.id[AXI_ID_W-1 -: IDX_W];
        route_ok_s   = int'(r_idx_s) < NUM_REQ;
        rready_sel_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_s[i]     = (r_idx_s == IDX_W'(i));
            s_rvalid[i]  = m_rvalid && hit_s[i];
            rready_sel_s = rready_sel_s | (s_rready[i] && hit_s[i]);
        end
        m_rready_s = route_ok_s ? rready_sel_s : 1'b1;
        retire_s   = m_rvalid && m_rready_s && r_s.last;
    end

    assign m_rready = m_rready_s;
    assign s_rid    = r_s.id[REQ_ID_W-1:0];
    assign s_rdata  = r_s.data;
    assign s_rresp  = r_s.resp;
    assign s_rlast  = r_s.last;

    // Outstanding counters: grant increments, last-beat handshake decrements, both cancel.
    always_comb begin
        err_d = err_q | (m_rvalid && !route_ok_s);
        for (int i = 0; i < NUM_REQ; i++) begin
            err_d = err_d | (retire_s && hit_s[i] && (outst_q[i] == 4'd0));
            case ({gnt_s[i], retire_s && hit_s[i] && (outst_q[i] != 4'd0)})
                2'b10:   outst_d[i] = outst_q[i] + 4'd1;
                2'b01:   outst_d[i] = outst_q[i] - 4'd1;
                default: outst_d[i] = outst_q[i];
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            ptr_q     <= '0;
            ar_q      <= '0;
            arvalid_q <= 1'b0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            ar_q      <= ar_d;
            arvalid_q <= arvalid_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    assign m_arid     = ar_q.id;
    assign m_araddr   = ar_q.addr;
    assign m_arlen    = ar_q.len;
    assign m_arsize   = ar_q.size;
    assign m_arburst  = ar_q.burst;
    assign m_arvalid  = arvalid_q;
    assign outst_cnt  = outst_q;
    assign err_sticky = err_q;

endmodule
